// File: rtl/pipeline_ext_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_ext_fifo                                                        |
// | Posted MEM-stage transaction buffer replayed on a req/ack external bus.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pipeline_ext_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  input  logic [68:0]      push_data,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [PTR_W:0]   fifo_level,
  output logic             mem_stall_req,
  output logic             bus_req,
  output logic             bus_write,
  output logic [3:0]       bus_mask,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wdata,
  input  logic             bus_ack,
  input  logic [31:0]      bus_rdata,
  output logic [31:0]      mem_external_result,
  output logic             result_valid
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [PTR_W:0] c_full_level = (PTR_W+1)'(DEPTH);

  state_t            r_state;
  logic [68:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_level;
  logic              r_read_pending;
  logic              r_bus_req;
  logic              r_result_valid;
  logic [31:0]       r_result;

  logic              w_push;
  logic              w_pop;
  logic [68:0]       w_head;

  assign fifo_full  = (r_level == c_full_level);
  assign fifo_empty = (r_level == '0);
  assign fifo_level = r_level;

  assign w_push = push_valid & ~fifo_full;
  assign w_pop  = (r_state == ST_BUSY) & bus_ack;

  // Head only changes on a pop, so the bus fields hold steady for a whole transaction.
  assign w_head = fifo_empty ? '0 : r_mem[r_rd_ptr];

  assign bus_req             = r_bus_req;
  assign bus_write           = w_head[68];
  assign bus_mask            = w_head[67:64];
  assign bus_addr            = w_head[63:32];
  assign bus_wdata           = w_head[31:0];
  assign mem_external_result = r_result;
  assign result_valid        = r_result_valid;
  assign mem_stall_req       = (push_valid & fifo_full) | r_read_pending;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_bus_req      <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_read_pending <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            r_state   <= ST_BUSY;
            r_bus_req <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (bus_ack) begin
            r_state   <= ST_IDLE;
            r_bus_req <= 1'b0;
            if (!w_head[68]) begin
              r_result       <= bus_rdata;
              r_result_valid <= 1'b1;
              r_read_pending <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_bus_req <= 1'b0;
        end
      endcase
      // A newly accepted read takes precedence over clearing the previous one.
      if (w_push && !push_data[68]) begin
        r_read_pending <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ext_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipeline_ext_fifo                                                     |
// | Scoreboard bench for pipeline_ext_fifo.                                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pipeline_ext_fifo;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk;
  logic             rst_n;
  logic             push_valid;
  logic [68:0]      push_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PTR_W:0]   fifo_level;
  logic             mem_stall_req;
  logic             bus_req;
  logic             bus_write;
  logic [3:0]       bus_mask;
  logic [31:0]      bus_addr;
  logic [31:0]      bus_wdata;
  logic             bus_ack;
  logic [31:0]      bus_rdata;
  logic [31:0]      mem_external_result;
  logic             result_valid;

  pipeline_ext_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .push_valid          (push_valid),
    .push_data           (push_data),
    .fifo_full           (fifo_full),
    .fifo_empty          (fifo_empty),
    .fifo_level          (fifo_level),
    .mem_stall_req       (mem_stall_req),
    .bus_req             (bus_req),
    .bus_write           (bus_write),
    .bus_mask            (bus_mask),
    .bus_addr            (bus_addr),
    .bus_wdata           (bus_wdata),
    .bus_ack             (bus_ack),
    .bus_rdata           (bus_rdata),
    .mem_external_result (mem_external_result),
    .result_valid        (result_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [68:0] exp_q[$];
  logic [31:0] res_q[$];
  logic [68:0] m_q[$];
  int          m_level = 0;
  logic        m_busy  = 1'b0;
  logic        m_pend  = 1'b0;

  function automatic logic [68:0] ent(input logic w, input logic [3:0] m,
                                      input logic [31:0] a, input logic [31:0] d);
    return {w, m, a, d};
  endfunction

  task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the reference model advances alongside the DUT.
  task automatic cyc(input logic pv, input logic [68:0] pd, input logic ack);
    logic        acc;
    logic        pop;
    logic [68:0] h;
    push_valid = pv;
    push_data  = pd;
    bus_ack    = ack;
    acc = pv && (m_level != DEPTH);
    pop = m_busy && ack;
    if (acc) begin
      exp_q.push_back(pd);
      m_q.push_back(pd);
      if (!pd[68]) res_q.push_back(bus_rdata);
    end
    #1;
    chk("stall", 69'(mem_stall_req), 69'((pv && (m_level == DEPTH)) || m_pend));
    @(posedge clk);
    if (pop) begin
      h = m_q.pop_front();
      if (!h[68]) m_pend = 1'b0;
    end
    if (acc && !pd[68]) m_pend = 1'b1;
    m_busy  = m_busy ? !ack : (m_level != 0);
    m_level = m_level + (acc ? 1 : 0) - (pop ? 1 : 0);
    #1;
    chk("level",   69'(fifo_level), 69'(m_level));
    chk("bus_req", 69'(bus_req),    69'(m_busy));
    chk("empty",   69'(fifo_empty), 69'(m_level == 0));
    chk("full",    69'(fifo_full),  69'(m_level == DEPTH));
    push_valid = 1'b0;
    bus_ack    = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((m_level != 0 || m_busy) && k < 60) begin
      cyc(1'b0, '0, m_busy);
      k++;
    end
    chk("drain_done", 69'(m_level), 69'd0);
  endtask

  // Monitor: compares the presented bus entry and returned read data against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus_req) begin
          if (exp_q.size() == 0) begin
            chk("bus_unexpected", 69'(bus_req), 69'd0);
          end else begin
            chk("bus_entry", {bus_write, bus_mask, bus_addr, bus_wdata}, exp_q[0]);
            if (bus_ack) void'(exp_q.pop_front());
          end
        end
        if (result_valid) begin
          if (res_q.size() == 0) begin
            chk("result_unexpected", 69'(result_valid), 69'd0);
          end else begin
            chk("result", 69'(mem_external_result), 69'(res_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    push_valid = 1'b0;
    push_data  = '0;
    bus_ack    = 1'b0;
    bus_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level",  69'(fifo_level),          69'd0);
    chk("rst_empty",  69'(fifo_empty),          69'd1);
    chk("rst_busreq", 69'(bus_req),             69'd0);
    chk("rst_result", 69'(mem_external_result), 69'd0);
    chk("rst_rvalid", 69'(result_valid),        69'd0);
    chk("rst_addr",   69'(bus_addr),            69'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write, acked after three cycles of bus_req
    cyc(1'b1, ent(1'b1, 4'hF, 32'h1F80_1000, 32'hDEAD_BEEF), 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    drain();

    // Write, write, read with read data returned to MEM
    bus_rdata = 32'h1234_5678;
    cyc(1'b1, ent(1'b1, 4'h3, 32'h0000_00A0, 32'h1111_0000), m_busy);
    cyc(1'b1, ent(1'b1, 4'hC, 32'h0000_00A4, 32'h2222_0000), m_busy);
    cyc(1'b1, ent(1'b0, 4'hF, 32'h0000_00A8, 32'h0), m_busy);
    drain();
    cyc(1'b0, '0, 1'b0);
    chk("result_held", 69'(mem_external_result), 69'h1234_5678);

    // Fill with no acks, overflow push dropped, then pop and push on full
    bus_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, ent(1'b1, 4'h1, 32'h0000_0100 + 32'(4 * i), 32'(i)), 1'b0);
    end
    cyc(1'b1, ent(1'b1, 4'h2, 32'h0000_0200, 32'h55), 1'b1);
    cyc(1'b1, ent(1'b1, 4'h4, 32'h0000_0204, 32'h66), 1'b0);
    drain();

    // Reset while busy with a read queued
    cyc(1'b1, ent(1'b1, 4'hF, 32'h0000_0300, 32'h1), 1'b0);
    cyc(1'b1, ent(1'b1, 4'hF, 32'h0000_0304, 32'h2), 1'b0);
    cyc(1'b1, ent(1'b0, 4'hF, 32'h0000_0308, 32'h0), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busreq", 69'(bus_req),             69'd0);
    chk("arst_level",  69'(fifo_level),          69'd0);
    chk("arst_stall",  69'(mem_stall_req),       69'd0);
    chk("arst_result", 69'(mem_external_result), 69'd0);
    exp_q.delete();
    res_q.delete();
    m_q.delete();
    m_level = 0;
    m_busy  = 1'b0;
    m_pend  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, '0, 1'b0);

    // Ten writes with zero-wait ack across pointer wrap
    begin
      int i;
      int guard;
      i = 0;
      guard = 0;
      while (i < 10 && guard < 200) begin
        if (m_level != DEPTH) begin
          cyc(1'b1, ent(1'b1, 4'hF, 32'h0000_0400 + 32'(4 * i), 32'(i)), m_busy);
          i++;
        end else begin
          cyc(1'b0, '0, m_busy);
        end
        guard++;
      end
      chk("wrap_pushed", 69'(i), 69'd10);
    end
    drain();

    repeat (2) cyc(1'b0, '0, 1'b0);
    chk("exp_q_empty", 69'(exp_q.size()), 69'd0);
    chk("res_q_empty", 69'(res_q.size()), 69'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
